rle_expand: RTL

Run-length decoder for the JPEG coefficient path, the inverse of the 8-lane run-length encoder. It consumes one (run, level) or end-of-block symbol per handshake and rebuilds the 64-coefficient zig-zag block as eight 64-bit words of eight 8-bit coefficients. Each word is emitted through a single-entry valid/ready output register. It sits between the entropy decoder and the inverse-zig-zag/dequantiser stage.

---
 rtl/rle_pkg.sv | 23 ++
 rtl/rle_expand_if.sv | 25 ++
 rtl/rle_lane_insert.sv | 17 +
 rtl/rle_expand.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared constants, FSM state type and lane addressing for the run-length expander.
// Lane 0 occupies the most significant byte of a word.
package rle_pkg;

  localparam int LANES  = 8;
  localparam int COEF_W = 8;
  localparam int BLK    = 64;
  localparam int WORD_W = LANES * COEF_W;
  localparam int POS_W  = $clog2(BLK);
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {
    S_ACCEPT,
    S_RUN,
    S_FLUSH
  } state_t;

  // Bit index of the least significant bit of a lane inside a word.
  function automatic logic [POS_W-1:0] lane_lsb(input logic [LANE_W-1:0] lane);
    return POS_W'((LANES - 1 - int'(lane)) * COEF_W);
  endfunction

endpackage

// File: rtl/rle_expand_if.sv
// Symbol-in / word-out handshake bundle of the run-length expander.
interface rle_expand_if;
  import rle_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_run;
  logic [COEF_W-1:0] in_level;
  logic              in_eob;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              err;

  modport master (
    output in_valid, in_run, in_level, in_eob, out_ready,
    input  in_ready, out_valid, out_data, out_last, err
  );

  modport slave (
    input  in_valid, in_run, in_level, in_eob, out_ready,
    output in_ready, out_valid, out_data, out_last, err
  );
endinterface

// File: rtl/rle_lane_insert.sv
// Overwrites one lane of a word with a coefficient; passes the word through when en is low.
module rle_lane_insert
  import rle_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  input  logic [COEF_W-1:0] level,
  input  logic              en,
  output logic [WORD_W-1:0] merged
);

  always_comb begin
    merged = word;
    if (en) merged[lane_lsb(lane) +: COEF_W] = level;
  end

endmodule

// File: rtl/rle_expand.sv
// Run-length decoder: (run, level) / EOB symbols in, 64-coefficient blocks out as
// eight words through a single-entry valid/ready output register.
module rle_expand
  import rle_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  rle_expand_if.slave bus
);

  state_t              state, state_nxt;
  logic [POS_W-1:0]    pos, pos_nxt, zl, zl_nxt, lane_gap;
  logic [COEF_W-1:0]   lvl_h, lvl_nxt, wr_level;
  logic [WORD_W-1:0]   acc, merged;
  logic [LANE_W-1:0]   lane, wr_lane;
  logic [POS_W:0]      pos_end, lane_end;
  logic                slot_free, accept, overrun, fits, zl_fits;
  logic                wr_en, emit, load, err_nxt;

  assign lane      = pos[LANE_W-1:0];
  assign lane_gap  = POS_W'(LANES) - POS_W'(lane);
  assign slot_free = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == S_ACCEPT) && slot_free;
  assign accept    = bus.in_valid && bus.in_ready;

  // Widened sums so a run reaching past index 63 is detected, not wrapped.
  assign pos_end  = {1'b0, pos} + {1'b0, bus.in_run};
  assign overrun  = pos_end > (POS_W+1)'(BLK - 1);
  assign lane_end = (POS_W+1)'(lane) + {1'b0, bus.in_run};
  assign fits     = lane_end <= (POS_W+1)'(LANES - 1);
  assign zl_fits  = zl <= POS_W'(LANES - 1);

  rle_lane_insert u_insert (
    .word   (acc),
    .lane   (wr_lane),
    .level  (wr_level),
    .en     (wr_en),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_ACCEPT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_ACCEPT: if (accept) begin
        if (bus.in_eob || overrun) state_nxt = S_FLUSH;
        else if (!fits)            state_nxt = S_RUN;
      end
      S_RUN:   if (slot_free && zl_fits) state_nxt = S_ACCEPT;
      S_FLUSH: if (slot_free && (pos + lane_gap) == '0) state_nxt = S_ACCEPT;
      default: state_nxt = S_ACCEPT;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    wr_en    = 1'b0;
    wr_lane  = lane;
    wr_level = bus.in_level;
    emit     = 1'b0;
    load     = 1'b0;
    err_nxt  = 1'b0;
    pos_nxt  = pos;
    zl_nxt   = zl;
    lvl_nxt  = lvl_h;
    unique case (state)
      S_ACCEPT: if (accept) begin
        load = 1'b1;
        if (bus.in_eob) begin
          // Zero fill happens in S_FLUSH.
        end else if (overrun) begin
          err_nxt = 1'b1;
        end else if (fits) begin
          wr_en   = 1'b1;
          wr_lane = lane_end[LANE_W-1:0];
          pos_nxt = pos + bus.in_run + POS_W'(1);
          emit    = (lane_end[LANE_W-1:0] == LANE_W'(LANES - 1));
        end else begin
          emit    = 1'b1;
          zl_nxt  = bus.in_run - lane_gap;
          lvl_nxt = bus.in_level;
          pos_nxt = pos + lane_gap;
        end
      end
      S_RUN: if (slot_free) begin
        load = 1'b1;
        if (zl_fits) begin
          wr_en    = 1'b1;
          wr_lane  = zl[LANE_W-1:0];
          wr_level = lvl_h;
          pos_nxt  = pos + zl + POS_W'(1);
          emit     = (zl == POS_W'(LANES - 1));
        end else begin
          emit    = 1'b1;
          zl_nxt  = zl - POS_W'(LANES);
          pos_nxt = pos + POS_W'(LANES);
        end
      end
      S_FLUSH: if (slot_free) begin
        load    = 1'b1;
        emit    = 1'b1;
        pos_nxt = pos + lane_gap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos           <= '0;
      zl            <= '0;
      lvl_h         <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= err_nxt;
      if (load) begin
        pos   <= pos_nxt;
        zl    <= zl_nxt;
        lvl_h <= lvl_nxt;
        acc   <= emit ? '0 : merged;
      end
      if (emit) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= merged;
        bus.out_last  <= (pos_nxt == '0);
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
